// File: rtl/ssd_multi_scan_driver.sv
// ssd_multi_scan_driver
// Time-multiplexed seven-segment display driver. One digit is lit per scan
// slot. Each slot opens with DEAD all-off cycles to suppress ghosting. Display
// data is double-buffered so that a frame never mixes old and new values.
// Optional feature macro: SSD_DIMMING_EN adds a BRIGHTNESS input and a
// free-running 4-bit PWM counter that gates the digit selects.
module ssd_multi_scan_driver #(
  parameter int unsigned DIGITS         = 4,
  parameter int unsigned SCAN_DIV       = 1024,
  parameter int unsigned DEAD           = 2,
  parameter bit          SEG_ACTIVE_LOW = 1'b1,
  parameter bit          SEL_ACTIVE_LOW = 1'b1
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic [DIGITS*5-1:0]   INPUT,
  input  logic                  LOAD,
  input  logic [DIGITS-1:0]     BLANK,
`ifdef SSD_DIMMING_EN
  input  logic [3:0]            BRIGHTNESS,
`endif
  output logic [7:0]            OUTPUT_SEG,
  output logic [DIGITS-1:0]     OUTPUT_SEL,
  output logic                  FRAME_DONE
);

  localparam int unsigned SLOT_W = $clog2(SCAN_DIV);
  localparam int unsigned IDX_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(SCAN_DIV - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(DIGITS - 1);

  // Idle levels of the output pins, used in reset.
  localparam logic [7:0]        SEG_OFF = SEG_ACTIVE_LOW ? 8'hFF : 8'h00;
  localparam logic [DIGITS-1:0] SEL_OFF = {DIGITS{SEL_ACTIVE_LOW}};

  // Hex value to active-high segments, bit order g..a.
  function automatic logic [6:0] hex2seg(input logic [3:0] hex);
    logic [6:0] seg;
    case (hex)
      4'h0: seg = 7'b0111111;
      4'h1: seg = 7'b0000110;
      4'h2: seg = 7'b1011011;
      4'h3: seg = 7'b1001111;
      4'h4: seg = 7'b1100110;
      4'h5: seg = 7'b1101101;
      4'h6: seg = 7'b1111101;
      4'h7: seg = 7'b0000111;
      4'h8: seg = 7'b1111111;
      4'h9: seg = 7'b1101111;
      4'hA: seg = 7'b1110111;
      4'hB: seg = 7'b1111100;
      4'hC: seg = 7'b0111001;
      4'hD: seg = 7'b1011110;
      4'hE: seg = 7'b1111001;
      default: seg = 7'b1110001; // F
    endcase
    return seg;
  endfunction

  logic [SLOT_W-1:0]    slot_q, slot_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [DIGITS*5-1:0]  pending_q, pending_d;
  logic [DIGITS*5-1:0]  active_q, active_d;
  logic [7:0]           seg_q, seg_d;
  logic [DIGITS-1:0]    sel_q, sel_d;
  logic                 frame_done_q, frame_done_d;
  logic                 boundary;
  logic [4:0]           cur_digit;
  logic [7:0]           seg_on;
  logic [DIGITS-1:0]    sel_on;
`ifdef SSD_DIMMING_EN
  logic [3:0]           pwm_q, pwm_d;
`endif

  // Scan position: slot counter and digit index, plus the frame boundary.
  // NOTE: every always_comb output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    slot_d   = slot_q + SLOT_W'(1);
    idx_d    = idx_q;
    boundary = (slot_q == SLOT_LAST) && (idx_q == IDX_LAST);
    if (slot_q == SLOT_LAST) begin
      slot_d = '0;
      idx_d  = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
    end
  end

  // Double buffer: pending follows every LOAD, active only moves at the
  // frame boundary. A LOAD in the boundary cycle bypasses pending.
  always_comb begin
    pending_d    = LOAD ? INPUT : pending_q;
    active_d     = active_q;
    frame_done_d = boundary;
    if (boundary) begin
      active_d = LOAD ? INPUT : pending_q;
    end
  end

  // Segment and select values for the current scan position.
  always_comb begin
    cur_digit = active_q[int'(idx_q)*5 +: 5];
    seg_on    = {cur_digit[4], hex2seg(cur_digit[3:0])};
    sel_on    = '0;
    if (32'(slot_q) >= DEAD) begin
      sel_on = DIGITS'(1) << idx_q;
    end
    // BLANK is live: it acts on the select of the very next output cycle.
    sel_on = sel_on & ~BLANK;
`ifdef SSD_DIMMING_EN
    if (pwm_q > BRIGHTNESS) begin
      sel_on = '0;
    end
`endif
    seg_d = SEG_ACTIVE_LOW ? ~seg_on : seg_on;
    sel_d = SEL_ACTIVE_LOW ? ~sel_on : sel_on;
  end

`ifdef SSD_DIMMING_EN
  // PWM phase counter, free running and wrapping every 16 cycles.
  always_comb begin
    pwm_d = pwm_q + 4'd1;
  end
`endif

  // State and output registers, all cleared asynchronously.
  // NOTE: sequential state uses non-blocking assignment so every register
  // samples the pre-edge value of the others. The data buffers are plain
  // flops, not a memory, so they are reset as well: after reset the display
  // shows all-zero data rather than whatever powered up.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      slot_q       <= '0;
      idx_q        <= '0;
      pending_q    <= '0;
      active_q     <= '0;
      seg_q        <= SEG_OFF;
      sel_q        <= SEL_OFF;
      frame_done_q <= 1'b0;
`ifdef SSD_DIMMING_EN
      pwm_q        <= '0;
`endif
    end else begin
      slot_q       <= slot_d;
      idx_q        <= idx_d;
      pending_q    <= pending_d;
      active_q     <= active_d;
      seg_q        <= seg_d;
      sel_q        <= sel_d;
      frame_done_q <= frame_done_d;
`ifdef SSD_DIMMING_EN
      pwm_q        <= pwm_d;
`endif
    end
  end

  assign OUTPUT_SEG = seg_q;
  assign OUTPUT_SEL = sel_q;
  assign FRAME_DONE = frame_done_q;

endmodule

// File: tb/tb_ssd_multi_scan_driver.sv
// tb_ssd_multi_scan_driver
// Directed bench for ssd_multi_scan_driver with DIGITS=4, SCAN_DIV=4, DEAD=1
// and both polarities active-low (16-cycle frame). Expected outputs for each
// cycle are predicted from the bench's own view of the scan position (frames
// are aligned on FRAME_DONE) and queued, then popped and compared once the
// DUT has produced that cycle. Build with SSD_DIMMING_EN to also exercise the
// BRIGHTNESS gating.
module tb_ssd_multi_scan_driver;

  localparam int DIGITS = 4;
  localparam int DEAD   = 1;
`ifdef SSD_DIMMING_EN
  localparam bit DIM_EN = 1'b1;
`else
  localparam bit DIM_EN = 1'b0;
`endif

  logic        CLK;
  logic        RST_N;
  logic [19:0] INPUT;
  logic        LOAD;
  logic [3:0]  BLANK;
`ifdef SSD_DIMMING_EN
  logic [3:0]  BRIGHTNESS;
`endif
  logic [7:0]  OUTPUT_SEG;
  logic [3:0]  OUTPUT_SEL;
  logic        FRAME_DONE;

  int compared   = 0;
  int mismatched = 0;
  int frame_no   = 0;

  typedef struct {
    logic [3:0] sel;
    logic [7:0] seg;
    logic       chk_seg;
    logic       fd;
  } exp_t;

  exp_t sb_q[$];

  // Reference segment patterns, active-high, bit order g..a.
  logic [6:0] seg_tbl [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  ssd_multi_scan_driver #(
    .DIGITS        (DIGITS),
    .SCAN_DIV      (4),
    .DEAD          (DEAD),
    .SEG_ACTIVE_LOW(1'b1),
    .SEL_ACTIVE_LOW(1'b1)
  ) dut (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .INPUT     (INPUT),
    .LOAD      (LOAD),
    .BLANK     (BLANK),
`ifdef SSD_DIMMING_EN
    .BRIGHTNESS(BRIGHTNESS),
`endif
    .OUTPUT_SEG(OUTPUT_SEG),
    .OUTPUT_SEL(OUTPUT_SEL),
    .FRAME_DONE(FRAME_DONE)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Bounded wait until FRAME_DONE is seen at a sample point.
  task automatic wait_frame_done();
    int n;
    n = 0;
    while (FRAME_DONE !== 1'b1 && n < 64) begin
      tick();
      n++;
    end
    check("frame_done_seen", 32'(FRAME_DONE), 32'd1);
  endtask

  // Starts at a sample point where FRAME_DONE=1 (scan state slot 0, digit 0)
  // and ends at the next such point. Output sample k reflects scan state k-1.
  // 'data' is what the frame is expected to display; if load_k is non-zero,
  // LOAD is held high with load_data for the cycle after sample load_k.
  task automatic run_frame(input logic [19:0] data, input logic [3:0] blank,
                           input int load_k, input logic [19:0] load_data,
                           input logic [3:0] bright);
    exp_t e;
    exp_t o;
    int s;
    int d;
    logic [4:0] f;
    logic [3:0] on;
    frame_no++;
    BLANK = blank;
`ifdef SSD_DIMMING_EN
    BRIGHTNESS = bright;
`endif
    for (int k = 1; k <= 16; k++) begin
      s  = (k - 1) % 4;
      d  = (k - 1) / 4;
      f  = data[d*5 +: 5];
      on = (s >= DEAD && !blank[d]) ? (4'b0001 << d) : 4'b0000;
      if (DIM_EN && (k - 1) > int'(bright)) on = 4'b0000;
      e.sel     = ~on;
      e.seg     = ~{f[4], seg_tbl[f[3:0]]};
      e.chk_seg = (on != 4'b0000);
      e.fd      = (k == 16);
      sb_q.push_back(e);
      tick();
      if (k == load_k) begin
        LOAD  = 1'b1;
        INPUT = load_data;
      end else begin
        LOAD  = 1'b0;
      end
      o = sb_q.pop_front();
      check($sformatf("f%0d_k%0d_sel", frame_no, k), 32'(OUTPUT_SEL), 32'(o.sel));
      if (o.chk_seg)
        check($sformatf("f%0d_k%0d_seg", frame_no, k), 32'(OUTPUT_SEG), 32'(o.seg));
      check($sformatf("f%0d_k%0d_fdone", frame_no, k), 32'(FRAME_DONE), 32'(o.fd));
    end
    LOAD = 1'b0;
  endtask

  // Watchdog: the directed sequence is a few hundred cycles.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [19:0] data_x;
    logic [19:0] data_y;
    data_x = {5'h0F, 5'h1E, 5'h0B, 5'h1A}; // F, E., b, A.
    data_y = {5'h17, 5'h09, 5'h0D, 5'h0C}; // 7., 9, d, C

    RST_N = 1'b0;
    INPUT = '0;
    LOAD  = 1'b0;
    BLANK = '0;
`ifdef SSD_DIMMING_EN
    BRIGHTNESS = 4'd15;
`endif

    // Reset state: everything idle.
    repeat (2) tick();
    check("rst_sel", 32'(OUTPUT_SEL), 32'h0F);
    check("rst_seg", 32'(OUTPUT_SEG), 32'hFF);
    check("rst_fdone", 32'(FRAME_DONE), 32'd0);

    RST_N = 1'b1;
    wait_frame_done();

    // All-zero data after reset; mid-frame LOAD must not show until boundary.
    run_frame(20'h00000, 4'b0000, 5, 20'h08864, 4'd15);
    // Digits 4,3,2,1; LOAD in the boundary cycle goes straight to next frame.
    run_frame(20'h08864, 4'b0000, 15, data_x, 4'd15);
    run_frame(data_x, 4'b0000, 0, 20'h00000, 4'd15);
    // Digit 2 blanked live; a mid-frame load of new data is held back.
    run_frame(data_x, 4'b0100, 8, data_y, 4'd15);
    run_frame(data_y, 4'b0000, 0, 20'h00000, 4'd15);
    // Reduced brightness (affects selects only when dimming is built in).
    run_frame(data_y, 4'b0000, 0, 20'h00000, 4'd3);
    run_frame(data_y, 4'b0000, 0, 20'h00000, 4'd15);

    // Two more cycles: output now shows digit 0 lit, then drop reset mid-slot.
    tick();
    tick();
    check("pre_rst_sel", 32'(OUTPUT_SEL), 32'h0E);
    #2;
    RST_N = 1'b0;
    #1;
    check("async_rst_sel", 32'(OUTPUT_SEL), 32'h0F);
    check("async_rst_seg", 32'(OUTPUT_SEG), 32'hFF);
    check("async_rst_fdone", 32'(FRAME_DONE), 32'd0);
    tick();
    RST_N = 1'b1;

    // Restart from index 0 with zero data: no LOAD since reset.
    wait_frame_done();
    run_frame(20'h00000, 4'b0000, 0, 20'h00000, 4'd15);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/ssd_multi_scan_driver.md
SSD_MULTI_SCAN_DRIVER -- requirements
Module: ssd_multi_scan_driver

Interface
REQ-001 SHALL have parameter DIGITS, default 4, number of multiplexed digits, legal range 1..8.
REQ-002 SHALL have parameter SCAN_DIV, default 1024, clock cycles per digit slot, legal range 4..65535.
REQ-003 SHALL have parameter DEAD, default 2, all-off cycles at start of each slot, legal range 0..SCAN_DIV-2.
REQ-004 SHALL have parameter SEG_ACTIVE_LOW, default 1, 1 = segment lines active low.
REQ-005 SHALL have parameter SEL_ACTIVE_LOW, default 1, 1 = select lines active low.
REQ-006 SHALL have port CLK, input, 1, sole clock, all state on rising edge.
REQ-007 SHALL have port RST_N, input, 1, reset, asynchronous, active low.
REQ-008 SHALL have port INPUT, input, DIGITS*5, per digit i: [5i+3:5i] hex value, [5i+4] decimal point.
REQ-009 SHALL have port LOAD, input, 1, capture strobe for INPUT.
REQ-010 SHALL have port BLANK, input, DIGITS, per-digit blank mask, 1 = digit dark.
REQ-011 SHALL have port OUTPUT_SEG, output, 8, registered segments, bit7 = dp, bits6:0 = g..a.
REQ-012 SHALL have port OUTPUT_SEL, output, DIGITS, registered one-hot digit select.
REQ-013 SHALL have port FRAME_DONE, output, 1, one-cycle pulse at each frame boundary.

Function
REQ-014 SHALL keep a slot counter 0..SCAN_DIV-1 and a digit index 0..DIGITS-1; the index advances when the slot counter wraps; index DIGITS-1 wraps to 0.
REQ-015 SHALL define the frame boundary as the cycle in which the slot counter is SCAN_DIV-1 and the index is DIGITS-1; FRAME_DONE SHALL be high in the cycle after it, for exactly one cycle.
REQ-016 SHALL hold INPUT in two registers: pending, written in any cycle LOAD=1, and active, which drives the display.
REQ-017 SHALL copy pending to active only at the frame boundary, so a frame never mixes old and new data.
REQ-018 SHALL, when LOAD=1 in the boundary cycle, load active directly from INPUT in that cycle.
REQ-019 SHALL keep active unchanged when LOAD has not been asserted since the last boundary; the same value is re-copied.
REQ-020 SHALL drive OUTPUT_SEL all inactive while the slot counter is below DEAD; otherwise SHALL assert only the bit for the current index.
REQ-021 SHALL force OUTPUT_SEL inactive for any digit whose BLANK bit is 1; BLANK is sampled live, not double-buffered.
REQ-022 SHALL decode the hex value to standard segments: 0-9, A, b, C, d, E, F. Example: active-high 1 = 7'b0000110 (g..a).
REQ-023 SHALL pass the dp bit to OUTPUT_SEG[7] unchanged.
REQ-024 SHALL invert segments when SEG_ACTIVE_LOW=1 and invert selects when SEL_ACTIVE_LOW=1.
REQ-025 SHALL register OUTPUT_SEG and OUTPUT_SEL together: one cycle of latency from the counter state to the outputs.

Reset
REQ-026 SHALL, while RST_N=0 and independent of CLK, clear the counters, index, pending, active and FRAME_DONE.
REQ-027 SHALL, while RST_N=0, drive OUTPUT_SEL and OUTPUT_SEG to their inactive level (all 1 when active-low).
REQ-028 SHALL, on reset release mid-frame, restart at index 0, slot 0, with the display showing all-zero data until the first boundary after a LOAD.

Configuration
REQ-029 SHALL, with SSD_DIMMING_EN defined, add port BRIGHTNESS (input, 4) and a free-running 4-bit PWM counter.
REQ-030 SHALL, with SSD_DIMMING_EN defined, gate the select so it is asserted only when the PWM count <= BRIGHTNESS; 15 = full on, 0 = 1/16 duty.
REQ-031 SHALL, without SSD_DIMMING_EN, have no BRIGHTNESS port and no PWM counter; selects run at full duty.

Verification (DIGITS=4, SCAN_DIV=4, DEAD=1, both active-low, frame = 16 cycles)
REQ-032 SHALL cover: reset, then LOAD with INPUT=20'h08864 (digits 4,3,2,1) -> after the next FRAME_DONE, slot 0 shows OUTPUT_SEL=4'b1110 with OUTPUT_SEG=8'h99 and slot 3 shows 4'b0111 with 8'hF9.
REQ-033 SHALL cover: the first cycle of every slot -> OUTPUT_SEL=4'b1111; FRAME_DONE pulses exactly every 16 cycles.
REQ-034 SHALL cover: LOAD mid-frame with new data -> outputs unchanged until the boundary; LOAD in the boundary cycle -> new data shown in the very next frame.
REQ-035 SHALL cover: RST_N dropped mid-slot -> OUTPUT_SEL=4'b1111 and OUTPUT_SEG=8'hFF immediately, without a clock edge.
REQ-036 SHALL cover: BLANK=4'b0100 -> digit 2 select never asserted, other digits unaffected.
REQ-037 SHALL cover, with SSD_DIMMING_EN and BRIGHTNESS=3: a select is asserted in exactly 4 of every 16 PWM phases of its active slot cycles.
